// File: rtl/freq_monitor_pkg.sv
// Shared definitions for the divided-clock frequency monitor: FSM encoding,
// synchronizer depth and a small arithmetic helper.
package freq_monitor_pkg;

  // Two flops is the minimum depth that gives a metastable sample a full cycle to settle.
  localparam int SYNC_STAGES = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/freq_monitor_edge_sync.sv
// Synchronizes a slow asynchronous input into the clk domain and flags its
// rising and falling edges; reusable for any slow single-bit input.
module freq_monitor_edge_sync
  import freq_monitor_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              sig_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
      sig_d  <= sync_q[STAGES-1];
    end
  end

  assign sig_s = sync_q[STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/freq_monitor.sv
// Measures period and high time of a slow clock sampled in the clk domain and
// declares lock after LOCK_CNT consecutive in-tolerance periods.
module freq_monitor
  import freq_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXPECTED = 16,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_mismatch,
  output logic             err_timeout
);

  localparam int               MC_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);
  localparam int unsigned      EXP_U     = EXPECTED;
  localparam int unsigned      TOL_U     = TOL;

  logic             sig_s;
  logic             rise;
  logic             fall;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W:0]   per_p1;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  match_nxt;
  logic             match;
  logic             timeout_hit;
  logic             meas_nxt;
  logic             mis_nxt;
  logic             to_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  freq_monitor_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise),
    .fall   (fall)
  );

  // Unsaturated period for the compare, so a saturated count can never alias into range.
  assign per_p1 = {1'b0, per_cnt} + (CNT_W + 1)'(1);
  assign match  = abs_diff(32'(per_p1), EXP_U) <= TOL_U;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    per_nxt     = rise ? '0 : sat_inc(per_cnt);
    hi_nxt      = rise ? '0 : (sig_s ? sat_inc(hi_cnt) : hi_cnt);
    timeout_hit = (state != ST_IDLE) && !rise && (per_nxt == TIMEOUT_V);
    state_nxt   = state;
    match_nxt   = match_cnt;
    meas_nxt    = 1'b0;
    mis_nxt     = 1'b0;
    to_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        // The first edge only starts the count; there is no prior rise to measure from.
        if (rise) begin
          state_nxt = ST_MEASURE;
          match_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          meas_nxt = 1'b1;
          if (!match) begin
            match_nxt = '0;
          end else if (match_cnt == LOCK_LAST) begin
            state_nxt = ST_LOCKED;
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + MC_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          meas_nxt = 1'b1;
          if (!match) begin
            state_nxt = ST_MEASURE;
            match_nxt = '0;
            mis_nxt   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        match_nxt = '0;
      end
    endcase

    // A rise in the threshold cycle suppresses timeout_hit, so the rise wins.
    if (timeout_hit) begin
      state_nxt = ST_IDLE;
      match_nxt = '0;
      to_nxt    = 1'b1;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      match_cnt    <= '0;
      period_out   <= '0;
      high_out     <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      per_cnt      <= per_nxt;
      hi_cnt       <= hi_nxt;
      match_cnt    <= match_nxt;
      if (meas_nxt) period_out <= sat_inc(per_cnt);
      if (fall)     high_out   <= sat_inc(hi_cnt);
      meas_valid   <= meas_nxt;
      locked       <= (state_nxt == ST_LOCKED);
      err_mismatch <= mis_nxt;
      err_timeout  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_freq_monitor.sv
// Bench for freq_monitor: two instances (TOL=0 and TOL=1) driven with directed
// and random pulse trains, checked against an event-level reference model.
module tb_freq_monitor;

  localparam int CNT_W    = 8;
  localparam int EXPECTED = 16;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 255;
  localparam int CMAX     = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst      [2];
  logic             sig      [2];
  logic [CNT_W-1:0] period_o [2];
  logic [CNT_W-1:0] high_o   [2];
  logic             mv       [2];
  logic             lk       [2];
  logic             emis     [2];
  logic             eto      [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model, advanced once per driven rising edge of sig_in.
  int   m_tol    [2] = '{0, 1};
  bit   m_armed  [2];
  int   m_last   [2];
  int   m_cnt    [2];
  logic m_locked [2] = '{1'b0, 1'b0};
  int   m_period [2];
  int   m_high   [2];
  int   m_nmeas  [2];
  int   m_nmis   [2];
  int   m_nto    [2];

  int o_nmeas   [2];
  int o_nmis    [2];
  int o_nto     [2];
  int o_meas_cyc[2];
  int o_to_cyc  [2];

  freq_monitor #(.CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(0), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .reset(rst[0]), .sig_in(sig[0]), .period_out(period_o[0]), .high_out(high_o[0]),
    .meas_valid(mv[0]), .locked(lk[0]), .err_mismatch(emis[0]), .err_timeout(eto[0])
  );

  freq_monitor #(.CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(1), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .reset(rst[1]), .sig_in(sig[1]), .period_out(period_o[1]), .high_out(high_o[1]),
    .meas_valid(mv[1]), .locked(lk[1]), .err_mismatch(emis[1]), .err_timeout(eto[1])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mv[d] === 1'b1)   begin o_nmeas[d]++; o_meas_cyc[d] = cyc; end
      if (emis[d] === 1'b1) o_nmis[d]++;
      if (eto[d] === 1'b1)  begin o_nto[d]++; o_to_cyc[d] = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_timeout(input int d);
    m_nto[d]++;
    m_armed[d]  = 1'b0;
    m_locked[d] = 1'b0;
    m_cnt[d]    = 0;
  endtask

  task automatic model_rise(input int d);
    int gap;
    int p;
    bit hit;
    gap = cyc - m_last[d];
    if (m_armed[d] && gap > TIMEOUT) model_timeout(d);
    if (!m_armed[d]) begin
      m_armed[d] = 1'b1;
    end else begin
      p = (gap > CMAX) ? CMAX : gap;
      m_period[d] = p;
      m_nmeas[d]++;
      hit = ((p > EXPECTED) ? p - EXPECTED : EXPECTED - p) <= m_tol[d];
      if (m_locked[d]) begin
        if (!hit) begin m_locked[d] = 1'b0; m_cnt[d] = 0; m_nmis[d]++; end
      end else if (hit) begin
        m_cnt[d]++;
        if (m_cnt[d] >= LOCK_CNT) begin m_locked[d] = 1'b1; m_cnt[d] = 0; end
      end else begin
        m_cnt[d] = 0;
      end
    end
    m_last[d] = cyc;
  endtask

  task automatic model_reset(input int d);
    m_armed[d]  = 1'b0;
    m_locked[d] = 1'b0;
    m_cnt[d]    = 0;
    m_period[d] = 0;
    m_high[d]   = 0;
  endtask

  // One period of sig_in: rise now, high for h cycles, low for the rest of p.
  task automatic pulse(input int d, input int p, input int h);
    sig[d] = 1'b1;
    model_rise(d);
    for (int k = 0; k < p; k++) begin
      if (k == h) sig[d] = 1'b0;
      if (k == 4) begin
        checks++;
        if (lk[d] !== m_locked[d]) begin
          errors++; $display("FAIL rise_locked dut%0d cyc=%0d: got %0b expected %0b", d, cyc, lk[d], m_locked[d]);
        end
        checks++;
        if (period_o[d] !== CNT_W'(m_period[d])) begin
          errors++; $display("FAIL rise_period dut%0d cyc=%0d: got %0d expected %0d", d, cyc, period_o[d], m_period[d]);
        end
        checks++;
        if (high_o[d] !== CNT_W'(m_high[d])) begin
          errors++; $display("FAIL rise_high dut%0d cyc=%0d: got %0d expected %0d", d, cyc, high_o[d], m_high[d]);
        end
      end
      @(posedge clk);
      #1;
    end
    m_high[d] = (h > CMAX) ? CMAX : h;
  endtask

  task automatic idle(input int d, input int n);
    tick(n);
    if (m_armed[d] && (cyc - m_last[d]) > TIMEOUT) model_timeout(d);
  endtask

  task automatic test_reset();
    tick(3);
    for (int d = 0; d < 2; d++) begin
      checks++; if (period_o[d] !== '0) begin errors++; $display("FAIL reset_period dut%0d: got %0d expected 0", d, period_o[d]); end
      checks++; if (high_o[d] !== '0)   begin errors++; $display("FAIL reset_high dut%0d: got %0d expected 0", d, high_o[d]); end
      checks++; if (mv[d] !== 1'b0)     begin errors++; $display("FAIL reset_meas_valid dut%0d: got %0b expected 0", d, mv[d]); end
      checks++; if (lk[d] !== 1'b0)     begin errors++; $display("FAIL reset_locked dut%0d: got %0b expected 0", d, lk[d]); end
      checks++; if (emis[d] !== 1'b0)   begin errors++; $display("FAIL reset_err_mismatch dut%0d: got %0b expected 0", d, emis[d]); end
      checks++; if (eto[d] !== 1'b0)    begin errors++; $display("FAIL reset_err_timeout dut%0d: got %0b expected 0", d, eto[d]); end
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    tick(3);
  endtask

  task automatic test_lock();
    repeat (5) pulse(0, 16, 8);
    checks++; if (lk[0] !== 1'b1)     begin errors++; $display("FAIL lock_locked: got %0b expected 1", lk[0]); end
    checks++; if (period_o[0] !== 8'd16) begin errors++; $display("FAIL lock_period: got %0d expected 16", period_o[0]); end
    checks++; if (high_o[0] !== 8'd8)   begin errors++; $display("FAIL lock_high: got %0d expected 8", high_o[0]); end
    checks++; if (o_nmeas[0] !== 4) begin errors++; $display("FAIL lock_meas_count: got %0d expected 4", o_nmeas[0]); end
    checks++; if (o_nmis[0] + o_nto[0] !== 0) begin errors++; $display("FAIL lock_err_count: got %0d expected 0", o_nmis[0] + o_nto[0]); end
  endtask

  task automatic test_mismatch();
    pulse(0, 18, 9);
    repeat (5) pulse(0, 16, 8);
    checks++; if (o_nmis[0] !== m_nmis[0]) begin errors++; $display("FAIL mismatch_count: got %0d expected %0d", o_nmis[0], m_nmis[0]); end
    checks++; if (o_nmis[0] !== 1)         begin errors++; $display("FAIL mismatch_once: got %0d expected 1", o_nmis[0]); end
    checks++; if (lk[0] !== 1'b1)          begin errors++; $display("FAIL mismatch_relock: got %0b expected 1", lk[0]); end
    checks++; if (o_nmeas[0] !== m_nmeas[0]) begin errors++; $display("FAIL mismatch_meas_count: got %0d expected %0d", o_nmeas[0], m_nmeas[0]); end
  endtask

  task automatic test_timeout();
    int to0;
    to0 = o_nto[0];
    idle(0, 300);
    checks++; if (o_nto[0] - to0 !== 1) begin errors++; $display("FAIL timeout_once: got %0d expected 1", o_nto[0] - to0); end
    checks++; if (o_to_cyc[0] - o_meas_cyc[0] !== TIMEOUT) begin
      errors++; $display("FAIL timeout_delay: got %0d expected %0d", o_to_cyc[0] - o_meas_cyc[0], TIMEOUT);
    end
    checks++; if (lk[0] !== 1'b0)       begin errors++; $display("FAIL timeout_locked: got %0b expected 0", lk[0]); end
    checks++; if (period_o[0] !== 8'd16) begin errors++; $display("FAIL timeout_period_hold: got %0d expected 16", period_o[0]); end
    checks++; if (o_nto[0] !== m_nto[0]) begin errors++; $display("FAIL timeout_count: got %0d expected %0d", o_nto[0], m_nto[0]); end
  endtask

  task automatic test_saturation();
    int meas0;
    int to0;
    meas0 = o_nmeas[0];
    to0   = o_nto[0];
    repeat (4) pulse(0, 300, 150);
    idle(0, 20);
    checks++; if (o_nmeas[0] !== meas0)   begin errors++; $display("FAIL sat_no_meas: got %0d expected %0d", o_nmeas[0], meas0); end
    checks++; if (o_nto[0] - to0 !== 4)   begin errors++; $display("FAIL sat_timeouts: got %0d expected 4", o_nto[0] - to0); end
    checks++; if (period_o[0] !== 8'd16)  begin errors++; $display("FAIL sat_period_hold: got %0d expected 16", period_o[0]); end
    checks++; if (high_o[0] !== 8'd150)   begin errors++; $display("FAIL sat_high: got %0d expected 150", high_o[0]); end
  endtask

  task automatic test_tolerance();
    int per_list [6] = '{15, 17, 16, 15, 14, 16};
    foreach (per_list[i]) pulse(1, per_list[i], per_list[i] / 2);
    checks++; if (o_nmis[1] !== 1)          begin errors++; $display("FAIL tol_mismatch: got %0d expected 1", o_nmis[1]); end
    checks++; if (lk[1] !== 1'b0)           begin errors++; $display("FAIL tol_unlocked: got %0b expected 0", lk[1]); end
    checks++; if (o_nmeas[1] !== m_nmeas[1]) begin errors++; $display("FAIL tol_meas_count: got %0d expected %0d", o_nmeas[1], m_nmeas[1]); end
  endtask

  task automatic test_reset_mid();
    repeat (5) pulse(0, 16, 8);
    sig[0] = 1'b1;
    model_rise(0);
    tick(6);
    #2 rst[0] = 1'b0;
    #1;
    checks++; if (period_o[0] !== '0) begin errors++; $display("FAIL mid_reset_period: got %0d expected 0", period_o[0]); end
    checks++; if (high_o[0] !== '0)   begin errors++; $display("FAIL mid_reset_high: got %0d expected 0", high_o[0]); end
    checks++; if ({mv[0], lk[0], emis[0], eto[0]} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {mv[0], lk[0], emis[0], eto[0]});
    end
    model_reset(0);
    sig[0] = 1'b0;
    tick(3);
    rst[0] = 1'b1;
    tick(3);
    repeat (3) pulse(0, 16, 8);
    checks++; if (o_nmeas[0] !== m_nmeas[0]) begin errors++; $display("FAIL mid_reset_meas_count: got %0d expected %0d", o_nmeas[0], m_nmeas[0]); end
  endtask

  task automatic test_random();
    int r;
    int p;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)     p = $urandom_range(260, 300);
        else if (r < 5) p = EXPECTED;
        else            p = $urandom_range(EXPECTED - 2, EXPECTED + 2);
        pulse(d, p, $urandom_range(2, p - 2));
      end
      idle(d, 20);
      checks++; if (o_nmeas[d] !== m_nmeas[d]) begin errors++; $display("FAIL rand_meas_count dut%0d: got %0d expected %0d", d, o_nmeas[d], m_nmeas[d]); end
      checks++; if (o_nmis[d] !== m_nmis[d])   begin errors++; $display("FAIL rand_mismatch_count dut%0d: got %0d expected %0d", d, o_nmis[d], m_nmis[d]); end
      checks++; if (o_nto[d] !== m_nto[d])     begin errors++; $display("FAIL rand_timeout_count dut%0d: got %0d expected %0d", d, o_nto[d], m_nto[d]); end
    end
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    sig[0] = 1'b0;
    sig[1] = 1'b0;
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_reset();
    test_lock();
    test_mismatch();
    test_timeout();
    test_saturation();
    test_tolerance();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
